bcd2count: RTL and testbench

BCD2COUNT -- requirements
Module: bcd2count

---
 rtl/bcd2count_pkg.sv | 32 +++
 rtl/bcd2count_radix_mac.sv | 24 ++
 rtl/bcd2count.sv | 163 ++++++++++++++++
 tb/tb_bcd2count.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd2count_pkg.sv
// Shared definitions for the BCD time-of-day to millisecond converter.
// State encoding, Horner step sequence and digit limits.
package bcd2count_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int unsigned N_STEPS   = 7;
   localparam logic [2:0]  LAST_STEP = 3'(N_STEPS - 1);

   localparam logic [3:0] DIG_MAX  = 4'd9;
   localparam logic [3:0] TENS_MAX = 4'd5;

   localparam logic [3:0] RADIX_6  = 4'd6;
   localparam logic [3:0] RADIX_10 = 4'd10;

   // Bit n set means step n multiplies by 10, otherwise by 6.
   localparam logic [7:0] RADIX10_SEQ = 8'b0111_1010;

   function automatic logic [3:0] radix_of(input logic [2:0] step);
      return RADIX10_SEQ[step] ? RADIX_10 : RADIX_6;
   endfunction

   function automatic logic digit_ok(input logic [3:0] d,
                                     input logic       tens);
      return d <= (tens ? TENS_MAX : DIG_MAX);
   endfunction

endpackage

// File: rtl/bcd2count_radix_mac.sv
// One Horner step: acc*radix + digit for radix 6 or 10.
// Shift-and-add only, so no general multiplier is inferred.
module radix_mac
   import bcd2count_pkg::*;
#(
   parameter int BITS = 26
) (
   input  logic [BITS-1:0] i_acc,
   input  logic [3:0]      i_radix,
   input  logic [3:0]      i_digit,
   output logic [BITS-1:0] o_result
);

   logic [BITS-1:0] w_x2;
   logic [BITS-1:0] w_hi;
   logic [BITS-1:0] w_dig;

   assign w_x2  = i_acc << 1;
   assign w_hi  = (i_radix == RADIX_10) ? (i_acc << 3) : (i_acc << 2);
   assign w_dig = {{(BITS-4){1'b0}}, i_digit};

   assign o_result = w_hi + w_x2 + w_dig;

endmodule

// File: rtl/bcd2count.sv
// BCD h:mm:ss.mmm to millisecond count, one Horner step per cycle.
// Illegal digits finish immediately with err set and count untouched.
module bcd2count
   import bcd2count_pkg::*;
#(
   parameter int BITS = 26
) (
   input  logic            NEclk,
   input  logic            Nreset,
   input  logic            start,
   input  logic [3:0]      bcd_h,
   input  logic [3:0]      bcd_min_1,
   input  logic [3:0]      bcd_min_0,
   input  logic [3:0]      bcd_s_1,
   input  logic [3:0]      bcd_s_0,
   input  logic [3:0]      bcd_ms_2,
   input  logic [3:0]      bcd_ms_1,
   input  logic [3:0]      bcd_ms_0,
   output logic [BITS-1:0] count,
   output logic            busy,
   output logic            done,
   output logic            err
);

   state_t          r_state, w_state_nx;
   logic [2:0]      r_step, w_step_nx;
   logic [BITS-1:0] r_acc, w_acc_nx;
   logic [BITS-1:0] r_count, w_count_nx;
   logic            r_busy, w_busy_nx;
   logic            r_done, w_done_nx;
   logic            r_err, w_err_nx;
   logic [3:0]      r_min_1, r_min_0, r_s_1, r_s_0;
   logic [3:0]      r_ms_2, r_ms_1, r_ms_0;

   logic            w_accept;
   logic            w_legal;
   logic            w_load;
   logic [3:0]      w_digit;
   logic [BITS-1:0] w_mac;

   assign w_legal = digit_ok(bcd_h, 1'b0)
                 && digit_ok(bcd_min_1, 1'b1)
                 && digit_ok(bcd_min_0, 1'b0)
                 && digit_ok(bcd_s_1, 1'b1)
                 && digit_ok(bcd_s_0, 1'b0)
                 && digit_ok(bcd_ms_2, 1'b0)
                 && digit_ok(bcd_ms_1, 1'b0)
                 && digit_ok(bcd_ms_0, 1'b0);

   assign w_accept = start && (r_state != S_CALC);

   always_comb begin
      w_digit = 4'd0;
      case (r_step)
         3'd0:    w_digit = r_min_1;
         3'd1:    w_digit = r_min_0;
         3'd2:    w_digit = r_s_1;
         3'd3:    w_digit = r_s_0;
         3'd4:    w_digit = r_ms_2;
         3'd5:    w_digit = r_ms_1;
         3'd6:    w_digit = r_ms_0;
         default: w_digit = 4'd0;
      endcase
   end

   radix_mac #(.BITS(BITS)) u_mac (
      .i_acc    (r_acc),
      .i_radix  (radix_of(r_step)),
      .i_digit  (w_digit),
      .o_result (w_mac)
   );

   always_comb begin
      w_state_nx = r_state;
      w_step_nx  = r_step;
      w_acc_nx   = r_acc;
      w_count_nx = r_count;
      w_busy_nx  = r_busy;
      w_done_nx  = 1'b0;
      w_err_nx   = r_err;
      w_load     = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            w_state_nx = S_IDLE;
            if (w_accept) begin
               w_load = 1'b1;
               if (w_legal) begin
                  w_state_nx = S_CALC;
                  w_acc_nx   = {{(BITS-4){1'b0}}, bcd_h};
                  w_step_nx  = 3'd0;
                  w_busy_nx  = 1'b1;
                  w_err_nx   = 1'b0;
               end else begin
                  w_state_nx = S_DONE;
                  w_done_nx  = 1'b1;
                  w_busy_nx  = 1'b0;
                  w_err_nx   = 1'b1;
               end
            end
         end
         S_CALC: begin
            w_acc_nx = w_mac;
            if (r_step == LAST_STEP) begin
               w_state_nx = S_DONE;
               w_count_nx = w_mac;
               w_done_nx  = 1'b1;
               w_busy_nx  = 1'b0;
               w_step_nx  = 3'd0;
            end else begin
               w_step_nx = r_step + 3'd1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge NEclk or negedge Nreset) begin
      if (!Nreset) begin
         r_state <= S_IDLE;
         r_step  <= 3'd0;
         r_acc   <= '0;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_step  <= w_step_nx;
         r_acc   <= w_acc_nx;
         r_count <= w_count_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
         r_err   <= w_err_nx;
      end
   end

   // Latched digits feed the step mux so later input changes are ignored.
   always_ff @(posedge NEclk or negedge Nreset) begin
      if (!Nreset) begin
         r_min_1 <= 4'd0;
         r_min_0 <= 4'd0;
         r_s_1   <= 4'd0;
         r_s_0   <= 4'd0;
         r_ms_2  <= 4'd0;
         r_ms_1  <= 4'd0;
         r_ms_0  <= 4'd0;
      end else if (w_load) begin
         r_min_1 <= bcd_min_1;
         r_min_0 <= bcd_min_0;
         r_s_1   <= bcd_s_1;
         r_s_0   <= bcd_s_0;
         r_ms_2  <= bcd_ms_2;
         r_ms_1  <= bcd_ms_1;
         r_ms_0  <= bcd_ms_0;
      end
   end

   assign count = r_count;
   assign busy  = r_busy;
   assign done  = r_done;
   assign err   = r_err;

endmodule

// File: tb/tb_bcd2count.sv
// Randomized bench for bcd2count against an arithmetic time model.
// Time values are packed as eight nibbles: h m1 m0 s1 s0 ms2 ms1 ms0.
module tb_bcd2count;

   localparam int BITS = 26;

   logic            NEclk = 1'b0;
   logic            Nreset = 1'b0;
   logic            start = 1'b0;
   logic [3:0]      bcd_h = '0, bcd_min_1 = '0, bcd_min_0 = '0;
   logic [3:0]      bcd_s_1 = '0, bcd_s_0 = '0;
   logic [3:0]      bcd_ms_2 = '0, bcd_ms_1 = '0, bcd_ms_0 = '0;
   logic [BITS-1:0] count;
   logic            busy, done, err;

   int              errors = 0;
   int              checks = 0;
   logic [BITS-1:0] exp_count = '0;

   bcd2count #(.BITS(BITS)) dut (
      .NEclk(NEclk), .Nreset(Nreset), .start(start),
      .bcd_h(bcd_h), .bcd_min_1(bcd_min_1), .bcd_min_0(bcd_min_0),
      .bcd_s_1(bcd_s_1), .bcd_s_0(bcd_s_0),
      .bcd_ms_2(bcd_ms_2), .bcd_ms_1(bcd_ms_1), .bcd_ms_0(bcd_ms_0),
      .count(count), .busy(busy), .done(done), .err(err)
   );

   always #5 NEclk = ~NEclk;

   function automatic int ref_ms(input logic [31:0] t);
      int h, m, s, f;
      h = int'(t[31:28]);
      m = int'(t[27:24]) * 10 + int'(t[23:20]);
      s = int'(t[19:16]) * 10 + int'(t[15:12]);
      f = int'(t[11:8]) * 100 + int'(t[7:4]) * 10 + int'(t[3:0]);
      return h * 3600000 + m * 60000 + s * 1000 + f;
   endfunction

   function automatic bit legal(input logic [31:0] t);
      return t[31:28] <= 9 && t[27:24] <= 5 && t[23:20] <= 9
          && t[19:16] <= 5 && t[15:12] <= 9 && t[11:8] <= 9
          && t[7:4] <= 9 && t[3:0] <= 9;
   endfunction

   // Inverse conversion (count -> watch digits -> BCD).
   function automatic logic [31:0] to_bcd(input int ms);
      int h, m, s, f, r;
      h = ms / 3600000;
      r = ms % 3600000;
      m = r / 60000;
      r = r % 60000;
      s = r / 1000;
      f = r % 1000;
      return {4'(h), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
              4'(f / 100), 4'((f / 10) % 10), 4'(f % 10)};
   endfunction

   function automatic logic [31:0] rand_time();
      return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
              4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
   endfunction

   task automatic drive(input logic [31:0] t);
      {bcd_h, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0,
       bcd_ms_2, bcd_ms_1, bcd_ms_0} = t;
   endtask

   task automatic tick();
      @(posedge NEclk);
      @(negedge NEclk);
   endtask

   // Present t with start for one edge (E0); returns at the following negedge.
   task automatic launch(input logic [31:0] t);
      drive(t);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      Nreset = 1'b0;
      drive('0);
      #12;
      checks += 4;
      if (count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
      @(negedge NEclk);
      Nreset = 1'b1;
      tick();
   endtask

   task automatic test_zero();
      launch(32'h0000_0000);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_e0: got %b want 1", busy); end
      repeat (6) tick();
      tick();
      checks += 4;
      if (count !== '0) begin errors++; $display("FAIL zero_count: got %0d want 0", count); end
      if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
      if (err !== 1'b0) begin errors++; $display("FAIL zero_err: got %b want 0", err); end
      if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_e7: got %b want 0", busy); end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL zero_done_drop: got %b want 0", done); end
      exp_count = '0;
   endtask

   task automatic test_one_hour();
      launch(32'h1000_0000);
      for (int k = 0; k < 7; k++) begin
         checks += 2;
         if (busy !== 1'b1) begin errors++; $display("FAIL hour_busy c%0d: got %b want 1", k, busy); end
         if (done !== 1'b0) begin errors++; $display("FAIL hour_done_early c%0d: got %b want 0", k, done); end
         drive($urandom);
         if (k < 6) tick();
      end
      tick();
      exp_count = BITS'(3600000);
      checks += 3;
      if (count !== exp_count) begin errors++; $display("FAIL hour_count: got %0d want %0d", count, exp_count); end
      if (done !== 1'b1) begin errors++; $display("FAIL hour_done: got %b want 1", done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL hour_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_max();
      logic [31:0] t;
      t = 32'h9595_9999;
      launch(t);
      repeat (6) tick();
      tick();
      exp_count = BITS'(ref_ms(t));
      checks += 3;
      if (count !== BITS'(35999999)) begin errors++; $display("FAIL max_count: got %0d want 35999999", count); end
      if (to_bcd(int'(count)) !== t) begin errors++; $display("FAIL max_roundtrip: got %h want %h", to_bcd(int'(count)), t); end
      if (done !== 1'b1) begin errors++; $display("FAIL max_done: got %b want 1", done); end
   endtask

   task automatic test_err();
      launch(32'h0006_0000);
      checks += 4;
      if (err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", err); end
      if (done !== 1'b1) begin errors++; $display("FAIL err_done: got %b want 1", done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %b want 0", busy); end
      if (count !== exp_count) begin errors++; $display("FAIL err_count: got %0d want %0d", count, exp_count); end
      tick();
      checks += 3;
      if (done !== 1'b0) begin errors++; $display("FAIL err_done_drop: got %b want 0", done); end
      if (err !== 1'b1) begin errors++; $display("FAIL err_hold: got %b want 1", err); end
      if (count !== exp_count) begin errors++; $display("FAIL err_count_hold: got %0d want %0d", count, exp_count); end
   endtask

   task automatic test_ignore_start();
      logic [31:0] t;
      t = 32'h0012_3456;
      launch(t);
      tick();
      tick();
      drive(32'h0000_0001);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL ign_done_e3: got %b want 0", done); end
      repeat (3) tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL ign_done_e6: got %b want 0", done); end
      tick();
      exp_count = BITS'(ref_ms(t));
      checks += 3;
      if (count !== exp_count) begin errors++; $display("FAIL ign_count: got %0d want %0d", count, exp_count); end
      if (done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b want 1", done); end
      if (err !== 1'b0) begin errors++; $display("FAIL ign_err: got %b want 0", err); end
      tick();
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL ign_queued_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL ign_queued_done: got %b want 0", done); end
   endtask

   task automatic test_reset_mid();
      launch(32'h2300_0000);
      repeat (3) tick();
      @(posedge NEclk);
      #2 Nreset = 1'b0;
      #1;
      checks += 3;
      if (count !== '0) begin errors++; $display("FAIL rmid_count: got %0d want 0", count); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
      exp_count = '0;
      repeat (5) tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL rmid_no_done: got %b want 0", done); end
      Nreset = 1'b1;
      launch(32'h0000_1234);
      repeat (6) tick();
      tick();
      exp_count = BITS'(1234);
      checks += 2;
      if (count !== exp_count) begin errors++; $display("FAIL rmid_count_new: got %0d want 1234", count); end
      if (done !== 1'b1) begin errors++; $display("FAIL rmid_done_new: got %b want 1", done); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ta, tb;
      ta = rand_time();
      tb = rand_time();
      launch(ta);
      repeat (6) tick();
      tick();
      checks += 2;
      if (count !== BITS'(ref_ms(ta))) begin errors++; $display("FAIL b2b_count_a: got %0d want %0d", count, ref_ms(ta)); end
      if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_a: got %b want 1", done); end
      launch(tb);
      checks += 2;
      if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b want 0", done); end
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
      repeat (6) tick();
      tick();
      exp_count = BITS'(ref_ms(tb));
      checks += 2;
      if (count !== exp_count) begin errors++; $display("FAIL b2b_count_b: got %0d want %0d", count, exp_count); end
      if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_b: got %b want 1", done); end
   endtask

   task automatic test_random();
      logic [31:0] t;
      int          pos;
      for (int n = 0; n < 40; n++) begin
         t = rand_time();
         if ($urandom_range(0, 4) == 0) begin
            pos = $urandom_range(0, 7);
            t[pos*4 +: 4] = 4'($urandom_range(6, 15));
         end
         launch(t);
         if (legal(t)) begin
            for (int k = 0; k < 6; k++) begin
               drive($urandom);
               tick();
            end
            tick();
            exp_count = BITS'(ref_ms(t));
            checks += 3;
            if (count !== exp_count) begin errors++; $display("FAIL rnd_count %h: got %0d want %0d", t, count, exp_count); end
            if (done !== 1'b1) begin errors++; $display("FAIL rnd_done %h: got %b want 1", t, done); end
            if (err !== 1'b0) begin errors++; $display("FAIL rnd_err %h: got %b want 0", t, err); end
         end else begin
            checks += 3;
            if (count !== exp_count) begin errors++; $display("FAIL rnd_bad_count %h: got %0d want %0d", t, count, exp_count); end
            if (done !== 1'b1) begin errors++; $display("FAIL rnd_bad_done %h: got %b want 1", t, done); end
            if (err !== 1'b1) begin errors++; $display("FAIL rnd_bad_err %h: got %b want 1", t, err); end
         end
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_one_hour();
      test_max();
      test_err();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
